// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a little-endian byte stream into words, writes them to imem, then releases the CPU
module imem_boot_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, wl_q, wl_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [WIDTH-1:0]  word_q, word_d;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    wl_d = wl_q;
    wptr_d = wptr_q;
    bidx_d = bidx_q;
    word_d = word_q;
    if (start && load_len != '0 && (state_q == IDLE || state_q == DONE)) begin
      state_d = RECV;
      len_d = load_len > MAX_LEN ? MAX_LEN : load_len;
      wl_d = '0;
      wptr_d = '0;
      bidx_d = '0;
    end
    if (state_q == RECV && rx_valid) begin
      word_d[{bidx_q, 3'b000} +: 8] = rx_data;
      bidx_d = bidx_q + 2'd1;
      state_d = bidx_q == 2'd3 ? WRITE : RECV;
    end
    if (state_q == WRITE) begin
      wl_d = wl_q + 1'b1;
      state_d = wl_q + 1'b1 == len_q ? DONE : RECV;
      wptr_d = wl_q + 1'b1 == len_q ? wptr_q : wptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      wl_q <= '0;
      wptr_q <= '0;
      bidx_q <= '0;
      word_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wl_q <= wl_d;
      wptr_q <= wptr_d;
      bidx_q <= bidx_d;
      word_q <= word_d;
    end
  end
  assign rx_ready = state_q == RECV;
  assign mem_we = state_q == WRITE;
  assign busy = state_q == RECV || state_q == WRITE;
  assign done = state_q == DONE;
  assign cpu_hold = state_q != DONE;
  assign words_loaded = wl_q;
  assign mem_addr = busy ? wptr_q : fetch_addr;
  assign mem_wdata = mem_we ? word_q : '0;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized loads checked against a byte-list model of the expected image
module tb_imem_boot_loader;
  logic clk = 0, rst_n = 0, start = 0, rx_valid = 0;
  logic [6:0] load_len = 0;
  logic [7:0] rx_data = 0;
  logic [5:0] fetch_addr = 0;
  logic rx_ready, mem_we, cpu_hold, busy, done;
  logic [5:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0] words_loaded;
  int cyc = 0, tests = 0, fails = 0;
  logic [31:0] shadow [64];
  int wr_addr [$];
  int wr_cyc [$];
  logic [31:0] wr_data [$];
  logic [7:0] pre [$];

  imem_boot_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fetch_addr(fetch_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction memory stand-in: captures every write the loader issues
  always @(negedge clk) if (mem_we === 1'b1) begin
    wr_addr.push_back(int'(mem_addr));
    wr_data.push_back(mem_wdata);
    wr_cyc.push_back(cyc);
    shadow[mem_addr] = mem_wdata;
    chk("ready_low_in_write", {31'd0, rx_ready}, 32'd0);
  end

  task automatic start_load(input logic [6:0] len, output int t0);
    start = 1;
    load_len = len;
    t0 = cyc;
    @(negedge clk);
    start = 0;
    if (len != 0) begin
      chk("start_busy", {31'd0, busy}, 1);
      chk("start_hold", {31'd0, cpu_hold}, 1);
      chk("start_ready", {31'd0, rx_ready}, 1);
      chk("start_done", {31'd0, done}, 0);
      chk("start_words", {25'd0, words_loaded}, 0);
      chk("start_addr", {26'd0, mem_addr}, 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    if (gap > 0) begin
      rx_valid = 0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1;
    rx_data = b;
    if (poke) begin
      start = 1;
      load_len = 7'd5;
    end
    for (int k = 0; k < 20 && rx_ready !== 1'b1; k++) @(negedge clk);
    chk("byte_accept", {31'd0, rx_ready}, 1);
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_load(input logic [6:0] len, input int glo, input int ghi, input bit poke);
    int n, t0;
    logic [7:0] b [$];
    n = len > 7'd64 ? 64 : int'(len);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    for (int i = 0; i < 4 * n; i++) b.push_back(i < pre.size() ? pre[i] : 8'($urandom));
    pre.delete();
    start_load(len, t0);
    for (int i = 0; i < 4 * n; i++)
      send_byte(b[i], i == 0 ? 0 : int'($urandom_range(ghi, glo)), poke && i == 2);
    rx_valid = 0;
    for (int k = 0; k < 400 && done !== 1'b1; k++) @(negedge clk);
    chk("load_done", {31'd0, done}, 1);
    chk("load_hold", {31'd0, cpu_hold}, 0);
    chk("load_busy", {31'd0, busy}, 0);
    chk("load_words", {25'd0, words_loaded}, 32'(n));
    chk("write_count", 32'(wr_addr.size()), 32'(n));
    if (ghi == 0) chk("release_cycle", 32'(cyc - t0), 32'(5 * n + 1));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk("write_addr", 32'(wr_addr[i]), 32'(i));
      chk("write_data", wr_data[i], {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
      if (ghi == 0) chk("write_cycle", 32'(wr_cyc[i] - t0), 32'(5 * i + 5));
    end
    fetch_addr = 6'($urandom);
    #1;
    chk("done_fetch_addr", {26'd0, mem_addr}, {26'd0, fetch_addr});
  endtask

  initial begin
    int t0, n0;
    logic [31:0] w0;
    rst_n = 0;
    fetch_addr = 6'h2A;
    repeat (2) @(negedge clk);
    chk("rst_hold", {31'd0, cpu_hold}, 1);
    chk("rst_ready", {31'd0, rx_ready}, 0);
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_words", {25'd0, words_loaded}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_addr", {26'd0, mem_addr}, 32'h2A);
    rst_n = 1;
    @(negedge clk);
    start_load(7'd0, t0);
    chk("len0_busy", {31'd0, busy}, 0);
    chk("len0_ready", {31'd0, rx_ready}, 0);
    chk("len0_done", {31'd0, done}, 0);
    chk("len0_addr", {26'd0, mem_addr}, 32'h2A);
    pre = '{8'h13, 8'h05, 8'h10, 8'h00};
    do_load(7'd1, 0, 0, 0);
    chk("single_word", wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h00100513);
    do_load(7'd3, 2, 2, 0);
    do_load(7'd6, 0, 2, 1);
    do_load(7'd100, 0, 0, 0);
    fetch_addr = 6'h15;
    do_load(7'd2, 0, 0, 0);
    wr_addr.delete();
    start_load(7'd3, t0);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h40 + i), 0, 0);
    w0 = 32'h43424140;
    rst_n = 0;
    rx_valid = 1;
    rx_data = 8'hEE;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_hold", {31'd0, cpu_hold}, 1);
    chk("midrst_ready", {31'd0, rx_ready}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_words", {25'd0, words_loaded}, 0);
    chk("midrst_addr", {26'd0, mem_addr}, {26'd0, fetch_addr});
    rst_n = 1;
    n0 = wr_addr.size();
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_write", 32'(wr_addr.size()), 32'(n0));
    chk("midrst_word0_kept", shadow[0], w0);
    rx_valid = 0;
    do_load(7'd2, 0, 0, 0);
    for (int r = 0; r < 4; r++) do_load(7'($urandom_range(8, 1)), 0, 2, r[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the 64-word instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions. It writes those instructions sequentially into the instruction memory write port and holds the pipeline until the image is complete. After loading it hands the memory address port back to the fetch stage, so the memory is shared between loader and fetch without a second port.

## Interface
- WIDTH, 32, instruction width in bits (fixed 4 bytes per word)
- DEPTH, 64, instruction memory words
- ADDR_W, 6, memory address width (log2 DEPTH)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load
- load_len  in  ADDR_W+1  number of words to load, sampled when start is accepted
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte this cycle
- fetch_addr  in  ADDR_W  word address from the fetch stage (PC[7:2])
- mem_addr  out  ADDR_W  address to the instruction memory
- mem_wdata  out  WIDTH  write data to the instruction memory
- mem_we  out  1  write enable to the instruction memory
- cpu_hold  out  1  pipeline stall/hold request
- busy  out  1  load in progress
- done  out  1  image loaded, CPU released
- words_loaded  out  ADDR_W+1  words written in the current or last load

## Operation
- Reset is synchronous and active-low, sampled on the rising clk edge.
- States: IDLE, RECV, WRITE, DONE. Reset value is IDLE.
- Output values during reset and in IDLE:
  - rx_ready=0, mem_we=0, mem_wdata=0
  - cpu_hold=1, busy=0, done=0, words_loaded=0
  - mem_addr=fetch_addr
- IDLE to RECV: start=1 with load_len!=0.
  - load_len>DEPTH is clamped to DEPTH.
  - The write pointer, byte index and words_loaded are cleared.
- start with load_len=0 is ignored and the state does not change.
- RECV:
  - rx_ready=1, busy=1.
  - A byte is accepted when rx_valid && rx_ready.
  - Byte k (k=0..3) of a word goes to bits [8k+7:8k], little-endian.
  - When byte 3 is accepted, go to WRITE.
- WRITE (one cycle):
  - rx_ready=0, mem_we=1, mem_addr=write pointer, mem_wdata=assembled word.
  - words_loaded increments at the end of the cycle.
  - If words_loaded+1 == len, go to DONE; otherwise increment the write pointer and go to RECV.
- DONE:
  - cpu_hold=0, done=1, busy=0, rx_ready=0, mem_we=0, mem_addr=fetch_addr.
  - words_loaded holds its final value.
- start in DONE with load_len!=0 begins a reload: go to RECV and raise cpu_hold the next cycle.
- start in RECV or WRITE is ignored.
- rx_valid in IDLE, WRITE or DONE is ignored. No byte is consumed, and the source must hold the byte.
- Memory address mux:
  - RECV: mem_addr=write pointer, mem_we=0.
  - WRITE: mem_addr=write pointer, mem_we=1.
  - IDLE and DONE: mem_addr=fetch_addr.
- Reset in the middle of a load returns to IDLE:
  - A partially assembled word is discarded.
  - Words already written stay in memory.
  - cpu_hold stays 1.
- The write pointer never exceeds DEPTH-1 and no wrap-around occurs, because of the clamp.

## Timing
- All outputs are registered state decodes. mem_addr is combinational from state, write pointer and fetch_addr.
- Cycle 0: start sampled. Cycle 1: first RECV cycle with rx_ready=1.
- With rx_valid held high, bytes of word i are accepted in cycles 5i+1..5i+4, and the WRITE for word i occurs in cycle 5i+5.
- For N words, the last write is in cycle 5N. done=1 and cpu_hold=0 from cycle 5N+1.
- Throughput is 5 cycles per word; rx_valid gaps only stretch RECV.
- The memory samples mem_we/mem_addr/mem_wdata on the clk edge that ends the WRITE cycle.
- Release latency is 1 cycle after the last write; fetch sees the new contents from the first DONE cycle.

## Test plan
- Reset, then idle: rst_n=0 for 2 cycles. Required response: cpu_hold=1, rx_ready=0, mem_we=0, done=0, mem_addr follows fetch_addr=0x2A.
- Single word: start with load_len=1, then bytes 0x13,0x05,0x10,0x00 back-to-back. Required response: mem_we=1 in cycle 5 with addr 0 and wdata 0x00100513; done=1 and cpu_hold=0 in cycle 6; words_loaded=1.
- Gapped stream: load_len=3 with rx_valid deasserted for 2 cycles between every byte. Required response: three writes to addr 0,1,2 with the correct words; no byte lost or duplicated; rx_ready=0 in each WRITE cycle.
- Clamp and ignore:
  - load_len=100 gives exactly 64 writes (addr 0..63), then DONE.
  - load_len=0 leaves the block in IDLE.
  - start pulsed during RECV does not disturb the count.
- Reset mid-load: rst_n=0 after 2 bytes of word 1. Required response: IDLE next cycle; word 0 remains written; no further mem_we; a new start reloads from addr 0.
- Reload from DONE: start with load_len=2. Required response: cpu_hold=1 the next cycle, mem_addr switches from fetch_addr to the write pointer, and words_loaded restarts at 0.
